block_mover: RTL and testbench

Parametrised memory block-move engine: copies a run of words from one address range to another, or fills a range with a constant. It sustains one word per granted cycle and copies overlapping ranges correctly. It replaces the two-cycle-per-word copier and sits between the process/channel controller (command side) and an arbitrated single-read/single-write RAM port pair (memory side).

---
 rtl/block_mover_pkg.sv | 21 ++
 rtl/block_mover_if.sv | 26 ++
 rtl/block_mover_hold_reg.sv | 44 ++++
 rtl/block_mover.sv | 194 +++++++++++++++++++
 tb/tb_block_mover.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/block_mover_pkg.sv
// Shared constants for the block mover: default widths, FSM state encoding,
// command mode codes and RAM direction codes.
package block_mover_pkg;

  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS    = 16;

  typedef enum logic [1:0] {
    MOVER_IDLE  = 2'd0,
    MOVER_RUN   = 2'd1,
    MOVER_DRAIN = 2'd2,
    MOVER_DONE  = 2'd3
  } mover_state_e;

  localparam logic MOVER_MODE_COPY = 1'b0;
  localparam logic MOVER_MODE_FILL = 1'b1;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

endpackage

// File: rtl/block_mover_if.sv
// Memory-side bus of the block mover: arbiter grant plus one read port and
// one write port of the shared RAM.
interface block_mover_if #(
  parameter int ADDR_BITS = block_mover_pkg::ADDRESS_BITS,
  parameter int DATA_BITS = block_mover_pkg::DATA_BITS
) ();

  logic                 memGrant;
  logic [ADDR_BITS-1:0] readAddress;
  logic                 readReadWriteMode;
  logic [DATA_BITS-1:0] readDataOut;
  logic [ADDR_BITS-1:0] writeAddress;
  logic                 writeReadWriteMode;
  logic [DATA_BITS-1:0] writeDataIn;

  modport master (
    input  memGrant, readDataOut,
    output readAddress, readReadWriteMode, writeAddress, writeReadWriteMode, writeDataIn
  );

  modport slave (
    output memGrant, readDataOut,
    input  readAddress, readReadWriteMode, writeAddress, writeReadWriteMode, writeDataIn
  );

endinterface

// File: rtl/block_mover_hold_reg.sv
// mover_hold_reg: one-entry skid register that parks a returning read word
// when the write port is not granted in the cycle the word arrives.
module mover_hold_reg #(
  parameter int DATA_BITS = block_mover_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 unload,
  input  logic [DATA_BITS-1:0] din,
  output logic                 valid,
  output logic [DATA_BITS-1:0] dout
);

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_BITS{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/block_mover.sv
// block_mover: one-word-per-granted-cycle copy engine with overlap-safe
// direction choice; fill mode is built only when BLOCK_MOVER_FILL_EN is defined.
module block_mover
  import block_mover_pkg::*;
#(
  parameter int ADDR_BITS = block_mover_pkg::ADDRESS_BITS,
  parameter int DATA_BITS = block_mover_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] srcAddress,
  input  logic [ADDR_BITS-1:0] dstAddress,
  input  logic [ADDR_BITS-1:0] wordCount,
  input  logic [DATA_BITS-1:0] fillValue,
  output logic                 busy,
  output logic                 finished,
  block_mover_if.master        mem
);

  localparam logic [ADDR_BITS-1:0] ONE_A  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ZERO_A = ADDR_BITS'(0);
  localparam logic [DATA_BITS-1:0] ZERO_D = DATA_BITS'(0);

  mover_state_e         state_q, state_d;
  logic                 back_q, back_d;
  logic                 pend_q, pend_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;

  logic                 fill_mode_s, fill_cmd_s, backward_s, active_s;
  logic                 read_go_s, write_go_s, data_ready_s;
  logic                 hold_load_s, hold_unload_s, hold_valid_s;
  logic [DATA_BITS-1:0] hold_data_s, copy_data_s, wr_data_s;
  logic [ADDR_BITS:0]   src_ext_s, dst_ext_s, end_ext_s;
  logic [ADDR_BITS-1:0] last_off_s;

  function automatic logic [ADDR_BITS-1:0] step_ptr(input logic [ADDR_BITS-1:0] ptr,
                                                   input logic back);
    if (back) return ptr - ONE_A;
    else      return ptr + ONE_A;
  endfunction

`ifdef BLOCK_MOVER_FILL_EN
  logic                 fill_q, fill_d;
  logic [DATA_BITS-1:0] fill_value_q, fill_value_d;

  assign fill_cmd_s  = (mode == MOVER_MODE_FILL);
  assign fill_mode_s = fill_q;

  always_comb begin
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    if (state_q == MOVER_IDLE && start) begin
      fill_d       = fill_cmd_s;
      fill_value_d = fillValue;
    end else begin
      fill_d       = fill_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_q       <= 1'b0;
      fill_value_q <= ZERO_D;
    end else begin
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

  assign wr_data_s = fill_mode_s ? fill_value_q : copy_data_s;
`else
  logic unused_fill_s;

  assign fill_cmd_s    = 1'b0;
  assign fill_mode_s   = 1'b0;
  assign wr_data_s     = copy_data_s;
  assign unused_fill_s = ^{mode, fillValue};
`endif

  // One extra address bit so src+count cannot wrap past dst in the overlap test.
  assign src_ext_s  = {1'b0, srcAddress};
  assign dst_ext_s  = {1'b0, dstAddress};
  assign end_ext_s  = src_ext_s + {1'b0, wordCount};
  assign last_off_s = wordCount - ONE_A;
  assign backward_s = !fill_cmd_s && (dst_ext_s > src_ext_s) && (dst_ext_s < end_ext_s);

  // A parked word is written in the same granted cycle a new read goes out,
  // so a grant gap costs exactly one cycle instead of stalling the read side.
  assign active_s      = (state_q == MOVER_RUN) || (state_q == MOVER_DRAIN);
  assign read_go_s     = mem.memGrant && !fill_mode_s && (state_q == MOVER_RUN) &&
                         (rd_left_q != ZERO_A);
  assign data_ready_s  = fill_mode_s || hold_valid_s || pend_q;
  assign write_go_s    = mem.memGrant && data_ready_s && active_s;
  assign hold_load_s   = pend_q && !mem.memGrant;
  assign hold_unload_s = hold_valid_s && mem.memGrant;
  assign copy_data_s   = hold_valid_s ? hold_data_s : mem.readDataOut;

  mover_hold_reg #(.DATA_BITS(DATA_BITS)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load   (hold_load_s),
    .unload (hold_unload_s),
    .din    (mem.readDataOut),
    .valid  (hold_valid_s),
    .dout   (hold_data_s)
  );

  always_comb begin
    state_d   = state_q;
    back_d    = back_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    pend_d    = read_go_s;

    if (read_go_s) begin
      rd_ptr_d  = step_ptr(rd_ptr_q, back_q);
      rd_left_d = rd_left_q - ONE_A;
    end else begin
      rd_left_d = rd_left_q;
    end

    if (write_go_s) begin
      wr_ptr_d  = step_ptr(wr_ptr_q, back_q);
      wr_left_d = wr_left_q - ONE_A;
    end else begin
      wr_left_d = wr_left_q;
    end

    case (state_q)
      MOVER_IDLE: begin
        if (start) begin
          back_d    = backward_s;
          rd_ptr_d  = backward_s ? srcAddress + last_off_s : srcAddress;
          wr_ptr_d  = backward_s ? dstAddress + last_off_s : dstAddress;
          rd_left_d = wordCount;
          wr_left_d = wordCount;
          state_d   = (wordCount == ZERO_A) ? MOVER_DONE : MOVER_RUN;
        end else begin
          state_d = MOVER_IDLE;
        end
      end
      MOVER_RUN: begin
        if (fill_mode_s) begin
          state_d = (write_go_s && wr_left_q == ONE_A) ? MOVER_DONE : MOVER_RUN;
        end else begin
          state_d = (read_go_s && rd_left_q == ONE_A) ? MOVER_DRAIN : MOVER_RUN;
        end
      end
      MOVER_DRAIN: begin
        state_d = (write_go_s && wr_left_q == ONE_A) ? MOVER_DONE : MOVER_DRAIN;
      end
      MOVER_DONE: begin
        state_d = MOVER_IDLE;
      end
      default: begin
        state_d = MOVER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MOVER_IDLE;
      back_q    <= 1'b0;
      pend_q    <= 1'b0;
      rd_ptr_q  <= ZERO_A;
      wr_ptr_q  <= ZERO_A;
      rd_left_q <= ZERO_A;
      wr_left_q <= ZERO_A;
    end else begin
      state_q   <= state_d;
      back_q    <= back_d;
      pend_q    <= pend_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
    end
  end

  assign busy                   = (state_q != MOVER_IDLE);
  assign finished               = (state_q == MOVER_DONE);
  assign mem.readAddress        = rd_ptr_q;
  assign mem.readReadWriteMode  = RAM_READ;
  assign mem.writeAddress       = wr_ptr_q;
  assign mem.writeReadWriteMode = write_go_s ? RAM_WRITE : RAM_READ;
  assign mem.writeDataIn        = write_go_s ? wr_data_s : ZERO_D;

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover: a registered-read RAM model behind the
// interface, per-scenario tasks with hand-computed write traces and timings.
module tb_block_mover;
  import block_mover_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, mode, busy, finished;
  logic [AW-1:0] src_s, dst_s, cnt_s;
  logic [DW-1:0] fill_s;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];

  logic [DW-1:0] ram [0:255];
  logic          ram_ready = 1'b0;

  block_mover_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mem_if ();

  block_mover #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .srcAddress (src_s),
    .dstAddress (dst_s),
    .wordCount  (cnt_s),
    .fillValue  (fill_s),
    .busy       (busy),
    .finished   (finished),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a >= 8'h10 && a <= 8'h15) return {8'h00, a - 8'h0F};
    else return {8'h01, a};
  endfunction

  // RAM model: synchronous write, data of readAddress returned next cycle.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i[7:0]);
      ram_ready <= 1'b1;
    end else if (mem_if.writeReadWriteMode == RAM_WRITE) begin
      ram[mem_if.writeAddress] <= mem_if.writeDataIn;
    end
    mem_if.readDataOut <= ram[mem_if.readAddress];
  end

  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [15:0] fv,
                         input logic [63:0] low_mask, input bit poke,
                         output int fin_cyc, output int fin_cnt, output int idle_cyc);
    fin_cyc = -1; fin_cnt = 0; idle_cyc = -1;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    @(posedge clk); #1;
    start = 1'b1; mode = m; src_s = s; dst_s = d; cnt_s = n; fill_s = fv;
    mem_if.memGrant = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 100; k++) begin
      mem_if.memGrant = (k < 64) ? ~low_mask[k] : 1'b1;
      if (poke && k == 2) begin
        start = 1'b1; src_s = 8'h00; dst_s = 8'h90; cnt_s = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (finished) begin fin_cnt++; fin_cyc = k; end
      if (mem_if.writeReadWriteMode == RAM_WRITE) begin
        wa_q.push_back(mem_if.writeAddress);
        wd_q.push_back(mem_if.writeDataIn);
        wc_q.push_back(k);
      end
      if (!busy) begin idle_cyc = k; break; end
      @(posedge clk); #1;
    end
    start = 1'b0; mem_if.memGrant = 1'b1;
    checks++;
    if (idle_cyc < 0) begin errors++; $display("FAIL cmd_timeout: busy still high after 100 cycles"); end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; mode = 1'b0; src_s = '0; dst_s = '0; cnt_s = '0; fill_s = '0;
    mem_if.memGrant = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", finished); end
    checks++; if (mem_if.readAddress !== 8'h00) begin errors++; $display("FAIL rst_raddr: got %h want 00", mem_if.readAddress); end
    checks++; if (mem_if.writeAddress !== 8'h00) begin errors++; $display("FAIL rst_waddr: got %h want 00", mem_if.writeAddress); end
    checks++; if (mem_if.writeDataIn !== 16'h0000) begin errors++; $display("FAIL rst_wdata: got %h want 0000", mem_if.writeDataIn); end
    checks++; if (mem_if.writeReadWriteMode !== RAM_READ) begin errors++; $display("FAIL rst_wmode: got %b want %b", mem_if.writeReadWriteMode, RAM_READ); end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_copy;
    int fc, fn, ic;
    run_cmd(1'b0, 8'h10, 8'h40, 8'd4, 16'h0000, 64'h0, 1'b0, fc, fn, ic);
    checks++; if (fc != 6 || fn != 1) begin errors++; $display("FAIL copy_finished: got cyc=%0d cnt=%0d want cyc=6 cnt=1", fc, fn); end
    checks++; if (ic != 7) begin errors++; $display("FAIL copy_idle: got %0d want 7", ic); end
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL copy_nwr: got %0d want 4", wa_q.size()); end
    for (int j = 0; j < 4; j++) begin
      if (j < wa_q.size()) begin
        checks++;
        if (wa_q[j] !== 8'(8'h40 + j) || wd_q[j] !== 16'(j + 1) || wc_q[j] != j + 2) begin
          errors++;
          $display("FAIL copy_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                   j, wa_q[j], wd_q[j], wc_q[j], 8'(8'h40 + j), 16'(j + 1), j + 2);
        end
      end
    end
    checks++; if (ram[8'h44] !== 16'h0144) begin errors++; $display("FAIL copy_guard: got %h want 0144", ram[8'h44]); end
  endtask

  task automatic test_overlap_busy;
    int fc, fn, ic;
    run_cmd(1'b0, 8'h10, 8'h12, 8'd4, 16'h0000, 64'h0, 1'b1, fc, fn, ic);
    checks++; if (fc != 6 || fn != 1 || ic != 7) begin errors++; $display("FAIL ovl_timing: got fin=%0d cnt=%0d idle=%0d want 6 1 7", fc, fn, ic); end
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL ovl_nwr: got %0d want 4", wa_q.size()); end
    for (int j = 0; j < 4; j++) begin
      if (j < wa_q.size()) begin
        checks++;
        if (wa_q[j] !== 8'(8'h15 - j) || wd_q[j] !== 16'(4 - j) || wc_q[j] != j + 2) begin
          errors++;
          $display("FAIL ovl_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                   j, wa_q[j], wd_q[j], wc_q[j], 8'(8'h15 - j), 16'(4 - j), j + 2);
        end
      end
    end
    checks++; if (ram[8'h12] !== 16'h0001 || ram[8'h15] !== 16'h0004) begin errors++; $display("FAIL ovl_mem: got %h %h want 0001 0004", ram[8'h12], ram[8'h15]); end
    checks++; if (ram[8'h90] !== 16'h0190) begin errors++; $display("FAIL busy_start: got %h want 0190", ram[8'h90]); end
  endtask

  task automatic test_fill;
    int fc, fn, ic, efc;
    logic [15:0] ed;
    run_cmd(1'b1, 8'h50, 8'h20, 8'd3, 16'h00A5, 64'h0, 1'b0, fc, fn, ic);
`ifdef BLOCK_MOVER_FILL_EN
    efc = 4;
`else
    efc = 5;
`endif
    checks++; if (fc != efc || fn != 1 || ic != efc + 1) begin errors++; $display("FAIL fill_timing: got fin=%0d cnt=%0d idle=%0d want fin=%0d", fc, fn, ic, efc); end
    checks++; if (wa_q.size() != 3) begin errors++; $display("FAIL fill_nwr: got %0d want 3", wa_q.size()); end
    for (int j = 0; j < 3; j++) begin
`ifdef BLOCK_MOVER_FILL_EN
      ed = 16'h00A5;
`else
      ed = 16'(16'h0150 + j);
`endif
      if (j < wa_q.size()) begin
        checks++;
        if (wa_q[j] !== 8'(8'h20 + j) || wd_q[j] !== ed || wc_q[j] != j + efc - 3) begin
          errors++;
          $display("FAIL fill_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                   j, wa_q[j], wd_q[j], wc_q[j], 8'(8'h20 + j), ed, j + efc - 3);
        end
      end
    end
  endtask

  task automatic test_grant_gaps;
    int fc, fn, ic;
    run_cmd(1'b0, 8'h30, 8'h80, 8'd6, 16'h0000, 64'h1554, 1'b0, fc, fn, ic);
    checks++; if (fc != 14 || fn != 1 || ic != 15) begin errors++; $display("FAIL gap_timing: got fin=%0d cnt=%0d idle=%0d want 14 1 15", fc, fn, ic); end
    checks++; if (wa_q.size() != 6) begin errors++; $display("FAIL gap_nwr: got %0d want 6", wa_q.size()); end
    for (int j = 0; j < 6; j++) begin
      if (j < wa_q.size()) begin
        checks++;
        if (wa_q[j] !== 8'(8'h80 + j) || wd_q[j] !== 16'(16'h0130 + j) || wc_q[j] != 3 + 2 * j) begin
          errors++;
          $display("FAIL gap_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                   j, wa_q[j], wd_q[j], wc_q[j], 8'(8'h80 + j), 16'(16'h0130 + j), 3 + 2 * j);
        end
      end
    end
  endtask

  task automatic test_zero;
    int fc, fn, ic;
    run_cmd(1'b0, 8'h10, 8'h50, 8'd0, 16'h0000, 64'h0, 1'b0, fc, fn, ic);
    checks++; if (fc != 1 || fn != 1 || ic != 2) begin errors++; $display("FAIL zero_timing: got fin=%0d cnt=%0d idle=%0d want 1 1 2", fc, fn, ic); end
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL zero_nwr: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid;
    int fc, fn, ic, wr_after;
    wr_after = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src_s = 8'h60; dst_s = 8'h70; cnt_s = 8'd8; mem_if.memGrant = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b fin=%b want 0 0", busy, finished); end
    checks++; if (mem_if.readAddress !== 8'h00 || mem_if.writeAddress !== 8'h00) begin errors++; $display("FAIL rmid_addr: got r=%h w=%h want 00 00", mem_if.readAddress, mem_if.writeAddress); end
    checks++; if (mem_if.writeDataIn !== 16'h0000 || mem_if.writeReadWriteMode !== RAM_READ) begin errors++; $display("FAIL rmid_wport: got d=%h m=%b want 0000 0", mem_if.writeDataIn, mem_if.writeReadWriteMode); end
    if (mem_if.writeReadWriteMode == RAM_WRITE) wr_after++;
    @(negedge clk); if (mem_if.writeReadWriteMode == RAM_WRITE) wr_after++;
    @(posedge clk); #1; reset = 1'b1;
    repeat (4) begin
      @(negedge clk); if (mem_if.writeReadWriteMode == RAM_WRITE) wr_after++;
    end
    checks++; if (wr_after != 0) begin errors++; $display("FAIL rmid_writes: got %0d want 0", wr_after); end
    checks++; if (ram[8'h70] !== 16'h0160 || ram[8'h71] !== 16'h0161) begin errors++; $display("FAIL rmid_done: got %h %h want 0160 0161", ram[8'h70], ram[8'h71]); end
    checks++; if (ram[8'h72] !== 16'h0172 || ram[8'h77] !== 16'h0177) begin errors++; $display("FAIL rmid_left: got %h %h want 0172 0177", ram[8'h72], ram[8'h77]); end
    run_cmd(1'b0, 8'h60, 8'h78, 8'd2, 16'h0000, 64'h0, 1'b0, fc, fn, ic);
    checks++; if (fc != 4 || fn != 1 || ic != 5) begin errors++; $display("FAIL rmid_next: got fin=%0d cnt=%0d idle=%0d want 4 1 5", fc, fn, ic); end
    checks++; if (ram[8'h78] !== 16'h0160 || ram[8'h79] !== 16'h0161) begin errors++; $display("FAIL rmid_nmem: got %h %h want 0160 0161", ram[8'h78], ram[8'h79]); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_overlap_busy();
    test_fill();
    test_grant_gaps();
    test_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
